// File: rtl/tx_framer.sv
// tx_framer: buffers host payload bytes and emits SYNC/LEN/payload/XOR-checksum frames
// to a serial transmitter, advancing one byte per read_enable strobe.
module tx_framer #(
  parameter int         DEPTH_LOG2     = 5,
  parameter int         LEN_DEPTH_LOG2 = 2,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic       clk_bit,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] d_out,
  output logic       d_out_valid,
  input  logic       read_enable,
  output logic       busy,
  output logic       trunc_err
);
  localparam logic [7:0] LAST_CNT = 8'((1 << DEPTH_LOG2) - 1);
  typedef enum logic [2:0] {IDLE, SYNC, LEN, DATA, CSUM} state_t;
  state_t state, nxt;
  logic [7:0] mem [2**DEPTH_LOG2];
  logic [7:0] lmem [2**LEN_DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wp, rp, rp_nxt;
  logic [LEN_DEPTH_LOG2:0] lwp, lrp;
  logic [7:0] wcnt, rem, len_r, csum, csum_nxt, d_nxt, head, head_nxt;
  logic data_full, len_full, len_empty, wr, pkt_end, pop_len, pop_data;
  assign data_full = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) &&
                     (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
  assign len_full  = (lwp[LEN_DEPTH_LOG2] != lrp[LEN_DEPTH_LOG2]) &&
                     (lwp[LEN_DEPTH_LOG2-1:0] == lrp[LEN_DEPTH_LOG2-1:0]);
  assign len_empty = lwp == lrp;
  assign s_ready   = !data_full && !len_full;
  assign wr        = s_valid && s_ready;
  assign pkt_end   = wr && (s_last || wcnt == LAST_CNT);
  assign pop_data  = state == DATA && read_enable;
  assign pop_len   = !len_empty && (state == IDLE || (state == CSUM && read_enable));
  assign rp_nxt    = rp + (DEPTH_LOG2+1)'(pop_data);
  assign head      = mem[rp[DEPTH_LOG2-1:0]];
  assign head_nxt  = mem[rp_nxt[DEPTH_LOG2-1:0]];
  assign d_out_valid = state != IDLE;
  assign busy        = state != IDLE;
  always_ff @(posedge clk_bit) begin
    if (wr) mem[wp[DEPTH_LOG2-1:0]] <= s_data;
    if (pkt_end) lmem[lwp[LEN_DEPTH_LOG2-1:0]] <= wcnt + 8'd1;
  end
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = len_empty ? IDLE : SYNC;
      SYNC:    if (read_enable) nxt = LEN;
      LEN:     if (read_enable) nxt = DATA;
      DATA:    if (read_enable && rem == 8'd1) nxt = CSUM;
      CSUM:    if (read_enable) nxt = len_empty ? IDLE : SYNC;
      default: nxt = IDLE;
    endcase
  end
  // d_out is loaded with the byte the next state will present, so it is a clean flop
  always_comb begin
    csum_nxt = (state == LEN && read_enable) ? len_r : pop_data ? csum ^ head : csum;
    d_nxt    = nxt == SYNC ? SYNC_BYTE :
               nxt == LEN  ? len_r :
               nxt == DATA ? head_nxt :
               nxt == CSUM ? csum_nxt : 8'h00;
  end
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      lwp       <= '0;
      lrp       <= '0;
      wcnt      <= '0;
      rem       <= '0;
      len_r     <= '0;
      csum      <= '0;
      d_out     <= '0;
      trunc_err <= 1'b0;
    end else begin
      wp   <= wp + (DEPTH_LOG2+1)'(wr);
      rp   <= rp_nxt;
      lwp  <= lwp + (LEN_DEPTH_LOG2+1)'(pkt_end);
      lrp  <= lrp + (LEN_DEPTH_LOG2+1)'(pop_len);
      wcnt <= pkt_end ? 8'd0 : wcnt + 8'(wr);
      if (pkt_end && !s_last) trunc_err <= 1'b1;
      if (pop_len) begin
        rem   <= lmem[lrp[LEN_DEPTH_LOG2-1:0]];
        len_r <= lmem[lrp[LEN_DEPTH_LOG2-1:0]];
      end else if (pop_data) rem <= rem - 8'd1;
      csum  <= csum_nxt;
      d_out <= d_nxt;
    end
  end
endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: directed checks of framing, checksum, back-pressure, truncation and reset.
module tb_tx_framer;
  logic clk_bit = 0, rst_n = 0, s_valid = 0, s_last = 0, read_enable = 0;
  logic [7:0] s_data = 0;
  logic s_ready, d_out_valid, busy, trunc_err;
  logic [7:0] d_out;
  int checks = 0, errors = 0;
  always #5 clk_bit = ~clk_bit;
  tx_framer dut (
    .clk_bit(clk_bit), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .d_out(d_out), .d_out_valid(d_out_valid),
    .read_enable(read_enable), .busy(busy), .trunc_err(trunc_err)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    @(negedge clk_bit);
    rst_n = 0; s_valid = 0; s_last = 0; read_enable = 0;
    repeat (2) @(negedge clk_bit);
    rst_n = 1;
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk_bit);
    s_valid = 1; s_data = d; s_last = l;
    while (!s_ready && n < 200) begin @(negedge clk_bit); n++; end
    chk("send_ready", 8'(s_ready), 8'd1);
    @(posedge clk_bit); #1;
    s_valid = 0; s_last = 0;
  endtask
  task automatic consume(input string tag, input logic [7:0] exp, input int gap);
    int n = 0;
    @(negedge clk_bit);
    while (!d_out_valid && n < 100) begin @(negedge clk_bit); n++; end
    repeat (gap) @(negedge clk_bit);
    chk({tag, "_valid"}, 8'(d_out_valid), 8'd1);
    chk(tag, d_out, exp);
    read_enable = 1;
    @(posedge clk_bit); #1;
    read_enable = 0;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt;
    do_reset;
    chk("rst_d_out", d_out, 8'h00);
    chk("rst_valid", 8'(d_out_valid), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_trunc", 8'(trunc_err), 8'd0);
    chk("rst_ready", 8'(s_ready), 8'd1);
    // single packet; LEN is folded into the checksum: 03^11^22^33 = 03
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
    @(negedge clk_bit);
    chk("single_valid_E", 8'(d_out_valid), 8'd0);
    @(negedge clk_bit);
    chk("single_valid_E1", 8'(d_out_valid), 8'd1);
    consume("single_sync", 8'hA5, 9);
    consume("single_len", 8'h03, 9);
    consume("single_d0", 8'h11, 9);
    consume("single_d1", 8'h22, 9);
    consume("single_d2", 8'h33, 9);
    consume("single_csum", 8'h03, 9);
    @(negedge clk_bit);
    chk("single_busy_end", 8'(busy), 8'd0);
    chk("single_valid_end", 8'(d_out_valid), 8'd0);
    // back-to-back frames
    send(8'h7F, 1); send(8'h80, 1);
    consume("b2b_sync0", 8'hA5, 9);
    consume("b2b_len0", 8'h01, 9);
    consume("b2b_d0", 8'h7F, 9);
    consume("b2b_csum0", 8'h7E, 9);
    @(negedge clk_bit);
    chk("b2b_gap_valid", 8'(d_out_valid), 8'd1);
    chk("b2b_gap_sync", d_out, 8'hA5);
    consume("b2b_sync1", 8'hA5, 9);
    consume("b2b_len1", 8'h01, 9);
    consume("b2b_d1", 8'h80, 9);
    consume("b2b_csum1", 8'h81, 9);
    @(negedge clk_bit);
    chk("b2b_busy_end", 8'(busy), 8'd0);
    // full data FIFO; csum = 20 ^ (0^1^...^31) = 20
    for (int i = 0; i < 32; i++) send(8'(i), i == 31);
    @(negedge clk_bit);
    chk("full_ready0", 8'(s_ready), 8'd0);
    consume("full_sync", 8'hA5, 1);
    consume("full_len", 8'h20, 1);
    @(negedge clk_bit);
    chk("full_d0", d_out, 8'h00);
    read_enable = 1;
    chk("full_pop_ready", 8'(s_ready), 8'd0);
    @(posedge clk_bit); #1;
    read_enable = 0;
    @(negedge clk_bit);
    chk("full_after_pop_ready", 8'(s_ready), 8'd1);
    for (int i = 1; i < 32; i++) consume("full_data", 8'(i), 1);
    consume("full_csum", 8'h20, 1);
    @(negedge clk_bit);
    chk("full_busy_end", 8'(busy), 8'd0);
    // length FIFO full: packet 1 leaves the FIFO as soon as it lands, so packet 5 fills it
    do_reset;
    for (int i = 1; i <= 4; i++) send(8'(i), 1);
    @(negedge clk_bit);
    chk("lenfull_ready4", 8'(s_ready), 8'd1);
    send(8'h05, 1);
    @(negedge clk_bit);
    chk("lenfull_ready5", 8'(s_ready), 8'd0);
    consume("lenfull_sync", 8'hA5, 1);
    consume("lenfull_len", 8'h01, 1);
    consume("lenfull_d0", 8'h01, 1);
    chk("lenfull_hold", 8'(s_ready), 8'd0);
    consume("lenfull_csum", 8'h00, 1);
    @(negedge clk_bit);
    chk("lenfull_release", 8'(s_ready), 8'd1);
    chk("lenfull_next_sync", d_out, 8'hA5);
    // truncation at 32 bytes, byte 33 starts a new packet
    do_reset;
    for (int i = 0; i < 32; i++) send(8'(i), 0);
    @(negedge clk_bit);
    chk("trunc_flag", 8'(trunc_err), 8'd1);
    chk("trunc_ready0", 8'(s_ready), 8'd0);
    consume("trunc_sync", 8'hA5, 1);
    consume("trunc_len", 8'h20, 1);
    consume("trunc_d0", 8'h00, 1);
    send(8'h55, 1);
    for (int i = 1; i < 32; i++) consume("trunc_data", 8'(i), 1);
    consume("trunc_csum", 8'h20, 1);
    chk("trunc_sticky", 8'(trunc_err), 8'd1);
    consume("trunc2_sync", 8'hA5, 1);
    consume("trunc2_len", 8'h01, 1);
    @(negedge clk_bit);
    chk("trunc2_d0", d_out, 8'h55);
    // reset while in DATA
    rst_n = 0;
    #1;
    chk("midrst_valid", 8'(d_out_valid), 8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_trunc", 8'(trunc_err), 8'd0);
    repeat (2) @(negedge clk_bit);
    rst_n = 1;
    chk("midrst_ready", 8'(s_ready), 8'd1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_bit);
      if (d_out_valid) cnt++;
    end
    chk("midrst_stale_cycles", 8'(cnt), 8'd0);
    send(8'h42, 1);
    consume("post_sync", 8'hA5, 9);
    consume("post_len", 8'h01, 9);
    consume("post_d0", 8'h42, 9);
    consume("post_csum", 8'h43, 9);
    @(negedge clk_bit);
    chk("post_busy_end", 8'(busy), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
